bti_arb2: RTL and testbench
===========================

Name: bti_arb2

Overview:
- Two-master round-robin arbiter that shares one bus-transaction slave, such as the boot ROM or a future data RAM.
- Typical masters: the rv32i instruction fetch port (m0) and a load/store or debug port (m1).
- Only one transaction is outstanding at a time. Each response is routed to the master that issued the request.
- Sits between the masters and the slave-side bus_trans_if at sim_top/SoC level.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
m0_req_vld  in  1  master 0 request valid
m0_req_rdy  out  1  master 0 request accepted
m0_req_addr  in  AW  master 0 address
m0_req_wr  in  1  master 0 write (1) / read (0)
m0_req_wdata  in  DW  master 0 write data
m0_rsp_vld  out  1  master 0 response valid
m0_rsp_rdy  in  1  master 0 response ready
m0_rsp_data  out  DW  master 0 read data
m1_*  same set of ports as m0_*, for master 1
s_req_vld  out  1  slave request valid
s_req_rdy  in  1  slave request ready
s_req_addr  out  AW  slave address
s_req_wr  out  1  slave write
s_req_wdata  out  DW  slave write data
s_rsp_vld  in  1  slave response valid
s_rsp_rdy  out  1  slave response ready
s_rsp_data  in  DW  slave read data

Behaviour:
- Handshake rules:
  - A transfer occurs on a cycle where vld & rdy.
  - Masters hold vld and payload stable until rdy is asserted.
  - The slave holds s_rsp_vld/s_rsp_data until s_rsp_rdy is asserted.
- Registered state:
  - FSM state: IDLE / REQ / RSP.
  - owner: 1 bit.
  - prio: 1 bit, the index of the master with priority.
- Reset (rst=1 at a clock edge):
  - state=IDLE, owner=0, prio=0.
  - All outputs are 0 in IDLE.
  - Reset takes effect even mid-transaction. Any in-flight slave transaction is dropped, so the slave must be reset in the same cycle.
- IDLE:
  - s_req_vld=0, s_rsp_rdy=0, all mX_req_rdy=0, all mX_rsp_vld=0.
  - If neither master requests, stay in IDLE.
  - If exactly one mX_req_vld is high, owner<=X and go to REQ.
  - If both are high, owner<=prio and go to REQ.
- REQ:
  - s_req_* is driven combinationally from the owner's req_* (s_req_vld = owner vld).
  - owner req_rdy = s_req_rdy. The non-owner req_rdy=0.
  - On s_req_vld & s_req_rdy, go to RSP.
  - If the owner drops vld (protocol violation), the FSM stays in REQ. This case is not checked.
- RSP:
  - The owner's rsp_vld = s_rsp_vld and rsp_data = s_rsp_data. s_rsp_rdy = owner rsp_rdy.
  - The non-owner rsp_vld=0 and rsp_data=0.
  - On s_rsp_vld & s_rsp_rdy: prio <= ~owner, then go to IDLE.
  - Writes also complete with a response, with data don't-care.
- Latency and throughput:
  - Request accept occurs no earlier than 1 cycle after vld rises.
  - Response forwarding adds zero cycles.
  - Minimum of 3 cycles per transaction (IDLE, REQ, RSP), so at most 1 transaction per 3 cycles.
- Fairness:
  - Under continuous contention, grants strictly alternate m0, m1, m0, ...
  - No master waits more than one transaction of the other master.
- Simultaneous events:
  - A request arriving in REQ or RSP from the non-owner is held off (rdy=0) until the next IDLE.
  - A response arriving in the same cycle the request is accepted is not consumed, because s_rsp_rdy=0 outside RSP. The slave must hold it.
- Outputs are combinational from registered state plus inputs. There are no combinational paths from s_rsp to s_req.

Test Plan:
1. Reset with both masters idle for 5 cycles -> all outputs 0, state IDLE, prio=0.
2. m0 read of addr 0x0000_0010 alone, slave rdy=1, response 0xDEAD_BEEF one cycle later -> m0_req_rdy high in cycle 2, m0_rsp_vld with 0xDEAD_BEEF, m1 outputs stay 0, transaction takes 3 cycles.
3. Both masters request continuously from reset (m0 addr 0x4, m1 addr 0x8) for 6 transactions -> grant order m0, m1, m0, m1, m0, m1; s_req_addr sequence 0x4, 0x8, 0x4, ...
4. m1 write of addr 0x20, data 0x1234_5678, with s_req_rdy low for 4 cycles -> s_req_vld/addr/wdata stable throughout and m1_req_rdy=0 until s_req_rdy rises; m0 asserting vld meanwhile is not accepted until after m1's response.
5. m0 holds m0_rsp_rdy=0 for 3 cycles while the slave has s_rsp_vld=1 with 0xCAFE_0001 -> s_rsp_rdy=0 for those cycles, data held, the FSM leaves RSP only in the cycle m0_rsp_rdy=1.
6. Assert rst while in RSP with m1 as owner -> next cycle state IDLE, all outputs 0, prio=0; a subsequent simultaneous request grants m0 first.

Source files
------------

// File: rtl/bti_arb2.sv
// Two-master round-robin arbiter in front of a single bus-transaction slave.
// One transaction is in flight at a time; the response is steered back to the issuing master.
module bti_arb2 #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          m0_req_vld_i,
    output logic          m0_req_rdy_o,
    input  logic [AW-1:0] m0_req_addr_i,
    input  logic          m0_req_wr_i,
    input  logic [DW-1:0] m0_req_wdata_i,
    output logic          m0_rsp_vld_o,
    input  logic          m0_rsp_rdy_i,
    output logic [DW-1:0] m0_rsp_data_o,
    input  logic          m1_req_vld_i,
    output logic          m1_req_rdy_o,
    input  logic [AW-1:0] m1_req_addr_i,
    input  logic          m1_req_wr_i,
    input  logic [DW-1:0] m1_req_wdata_i,
    output logic          m1_rsp_vld_o,
    input  logic          m1_rsp_rdy_i,
    output logic [DW-1:0] m1_rsp_data_o,
    output logic          s_req_vld_o,
    input  logic          s_req_rdy_i,
    output logic [AW-1:0] s_req_addr_o,
    output logic          s_req_wr_o,
    output logic [DW-1:0] s_req_wdata_o,
    input  logic          s_rsp_vld_i,
    output logic          s_rsp_rdy_o,
    input  logic [DW-1:0] s_rsp_data_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q, prio_d;

    logic          own_req_vld;
    logic [AW-1:0] own_req_addr;
    logic          own_req_wr;
    logic [DW-1:0] own_req_wdata;
    logic          own_rsp_rdy;

    assign own_req_vld   = owner_q ? m1_req_vld_i   : m0_req_vld_i;
    assign own_req_addr  = owner_q ? m1_req_addr_i  : m0_req_addr_i;
    assign own_req_wr    = owner_q ? m1_req_wr_i    : m0_req_wr_i;
    assign own_req_wdata = owner_q ? m1_req_wdata_i : m0_req_wdata_i;
    assign own_rsp_rdy   = owner_q ? m1_rsp_rdy_i   : m0_rsp_rdy_i;

    // NOTE: reset is synchronous, and every state register uses <= so all flops update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
        end
    end

    // NOTE: every output and next-state signal gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        prio_d        = prio_q;
        m0_req_rdy_o  = 1'b0;
        m1_req_rdy_o  = 1'b0;
        m0_rsp_vld_o  = 1'b0;
        m1_rsp_vld_o  = 1'b0;
        m0_rsp_data_o = '0;
        m1_rsp_data_o = '0;
        s_req_vld_o   = 1'b0;
        s_req_addr_o  = '0;
        s_req_wr_o    = 1'b0;
        s_req_wdata_o = '0;
        s_rsp_rdy_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (m0_req_vld_i || m1_req_vld_i) begin
                    owner_d = (m0_req_vld_i && m1_req_vld_i) ? prio_q : m1_req_vld_i;
                    state_d = REQ;
                end
            end
            REQ: begin
                s_req_vld_o   = own_req_vld;
                s_req_addr_o  = own_req_addr;
                s_req_wr_o    = own_req_wr;
                s_req_wdata_o = own_req_wdata;
                if (owner_q) m1_req_rdy_o = s_req_rdy_i;
                else         m0_req_rdy_o = s_req_rdy_i;
                if (own_req_vld && s_req_rdy_i) state_d = RSP;
            end
            RSP: begin
                s_rsp_rdy_o = own_rsp_rdy;
                if (owner_q) begin
                    m1_rsp_vld_o  = s_rsp_vld_i;
                    m1_rsp_data_o = s_rsp_data_i;
                end else begin
                    m0_rsp_vld_o  = s_rsp_vld_i;
                    m0_rsp_data_o = s_rsp_data_i;
                end
                // The master just served loses priority for the next contended grant.
                if (s_rsp_vld_i && own_rsp_rdy) begin
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_bti_arb2.sv
// Directed bench for bti_arb2: reset, single transfers, contention order,
// request/response backpressure and reset in the middle of a transaction.
module tb_bti_arb2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        m0_req_vld_i, m0_req_rdy_o, m0_req_wr_i, m0_rsp_vld_o, m0_rsp_rdy_i;
    logic [31:0] m0_req_addr_i, m0_req_wdata_i, m0_rsp_data_o;
    logic        m1_req_vld_i, m1_req_rdy_o, m1_req_wr_i, m1_rsp_vld_o, m1_rsp_rdy_i;
    logic [31:0] m1_req_addr_i, m1_req_wdata_i, m1_rsp_data_o;
    logic        s_req_vld_o, s_req_rdy_i, s_req_wr_o, s_rsp_vld_i, s_rsp_rdy_o;
    logic [31:0] s_req_addr_o, s_req_wdata_o, s_rsp_data_i;

    int checks = 0;
    int errors = 0;

    bti_arb2 #(.AW(32), .DW(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_vld_i(m0_req_vld_i), .m0_req_rdy_o(m0_req_rdy_o), .m0_req_addr_i(m0_req_addr_i),
        .m0_req_wr_i(m0_req_wr_i), .m0_req_wdata_i(m0_req_wdata_i), .m0_rsp_vld_o(m0_rsp_vld_o),
        .m0_rsp_rdy_i(m0_rsp_rdy_i), .m0_rsp_data_o(m0_rsp_data_o),
        .m1_req_vld_i(m1_req_vld_i), .m1_req_rdy_o(m1_req_rdy_o), .m1_req_addr_i(m1_req_addr_i),
        .m1_req_wr_i(m1_req_wr_i), .m1_req_wdata_i(m1_req_wdata_i), .m1_rsp_vld_o(m1_rsp_vld_o),
        .m1_rsp_rdy_i(m1_rsp_rdy_i), .m1_rsp_data_o(m1_rsp_data_o),
        .s_req_vld_o(s_req_vld_o), .s_req_rdy_i(s_req_rdy_i), .s_req_addr_o(s_req_addr_o),
        .s_req_wr_o(s_req_wr_o), .s_req_wdata_o(s_req_wdata_o), .s_rsp_vld_i(s_rsp_vld_i),
        .s_rsp_rdy_o(s_rsp_rdy_o), .s_rsp_data_i(s_rsp_data_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req_vld_i = 0; m0_req_addr_i = 0; m0_req_wr_i = 0; m0_req_wdata_i = 0; m0_rsp_rdy_i = 0;
        m1_req_vld_i = 0; m1_req_addr_i = 0; m1_req_wr_i = 0; m1_req_wdata_i = 0; m1_rsp_rdy_i = 0;
        s_req_rdy_i = 0; s_rsp_vld_i = 0; s_rsp_data_i = 0;
    endtask

    task automatic check_all_zero(input string tag);
        #1;
        check({tag, "_ctl"}, {26'd0, s_req_vld_o, s_rsp_rdy_o, m0_req_rdy_o, m1_req_rdy_o,
                              m0_rsp_vld_o, m1_rsp_vld_o}, 32'd0);
        check({tag, "_data"}, s_req_addr_o | s_req_wdata_o | m0_rsp_data_o | m1_rsp_data_o
                              | {31'd0, s_req_wr_o}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        rst_i = 1;
        #1;

        // 1. Reset with both masters idle.
        for (int i = 0; i < 5; i++) tick();
        check_all_zero("rst");
        check("rst_state", {30'd0, dut.state_q}, 32'd0);
        check("rst_prio", {31'd0, dut.prio_q}, 32'd0);
        rst_i = 0;

        // 2. Lone m0 read.
        m0_req_vld_i = 1; m0_req_addr_i = 32'h10; s_req_rdy_i = 1;
        #1;
        check("t2_c1_rdy", {31'd0, m0_req_rdy_o}, 32'd0);
        check("t2_c1_svld", {31'd0, s_req_vld_o}, 32'd0);
        tick();
        check("t2_c2_rdy", {31'd0, m0_req_rdy_o}, 32'd1);
        check("t2_c2_svld", {31'd0, s_req_vld_o}, 32'd1);
        check("t2_c2_addr", s_req_addr_o, 32'h10);
        check("t2_c2_wr", {31'd0, s_req_wr_o}, 32'd0);
        check("t2_c2_m1rdy", {31'd0, m1_req_rdy_o}, 32'd0);
        tick();
        m0_req_vld_i = 0; s_req_rdy_i = 0;
        s_rsp_vld_i = 1; s_rsp_data_i = 32'hDEAD_BEEF; m0_rsp_rdy_i = 1;
        #1;
        check("t2_c3_rvld", {31'd0, m0_rsp_vld_o}, 32'd1);
        check("t2_c3_rdata", m0_rsp_data_o, 32'hDEAD_BEEF);
        check("t2_c3_srdy", {31'd0, s_rsp_rdy_o}, 32'd1);
        check("t2_c3_m1", {31'd0, m1_rsp_vld_o} | m1_rsp_data_o, 32'd0);
        tick();
        clear_inputs();
        check("t2_done_state", {30'd0, dut.state_q}, 32'd0);
        check_all_zero("t2_done");

        // 3. Continuous contention from reset: grants alternate m0, m1, ...
        rst_i = 1; tick(); rst_i = 0;
        m0_req_vld_i = 1; m0_req_addr_i = 32'h4;
        m1_req_vld_i = 1; m1_req_addr_i = 32'h8;
        m0_rsp_rdy_i = 1; m1_rsp_rdy_i = 1;
        for (int t = 0; t < 6; t++) begin
            #1;
            check($sformatf("t3_%0d_idle", t), {30'd0, m0_req_rdy_o, m1_req_rdy_o}, 32'd0);
            tick();
            s_req_rdy_i = 1;
            #1;
            check($sformatf("t3_%0d_addr", t), s_req_addr_o, (t % 2 == 0) ? 32'h4 : 32'h8);
            check($sformatf("t3_%0d_grant", t), {30'd0, m0_req_rdy_o, m1_req_rdy_o},
                  (t % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            s_req_rdy_i = 0; s_rsp_vld_i = 1; s_rsp_data_i = 32'h100 + t;
            #1;
            check($sformatf("t3_%0d_rsp", t), {30'd0, m0_rsp_vld_o, m1_rsp_vld_o},
                  (t % 2 == 0) ? 32'd2 : 32'd1);
            check($sformatf("t3_%0d_rdata", t), m0_rsp_data_o | m1_rsp_data_o, 32'h100 + t);
            tick();
            s_rsp_vld_i = 0; s_rsp_data_i = 0;
        end
        clear_inputs();

        // 4. m1 write with request backpressure; m0 arrives meanwhile.
        m1_req_vld_i = 1; m1_req_addr_i = 32'h20; m1_req_wr_i = 1; m1_req_wdata_i = 32'h1234_5678;
        tick();
        m0_req_vld_i = 1; m0_req_addr_i = 32'h4;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("t4_hold%0d_vld", i), {31'd0, s_req_vld_o}, 32'd1);
            check($sformatf("t4_hold%0d_addr", i), s_req_addr_o, 32'h20);
            check($sformatf("t4_hold%0d_wdata", i), s_req_wdata_o, 32'h1234_5678);
            check($sformatf("t4_hold%0d_wr", i), {31'd0, s_req_wr_o}, 32'd1);
            check($sformatf("t4_hold%0d_rdy", i), {30'd0, m0_req_rdy_o, m1_req_rdy_o}, 32'd0);
            tick();
        end
        s_req_rdy_i = 1;
        #1;
        check("t4_accept", {30'd0, m0_req_rdy_o, m1_req_rdy_o}, 32'd1);
        tick();
        m1_req_vld_i = 0; s_req_rdy_i = 0; s_rsp_vld_i = 1; m1_rsp_rdy_i = 1;
        #1;
        check("t4_rsp", {29'd0, m1_rsp_vld_o, m0_rsp_vld_o, m0_req_rdy_o}, 32'd4);
        tick();
        s_rsp_vld_i = 0; m1_rsp_rdy_i = 0;
        #1;
        check("t4_idle_m0rdy", {31'd0, m0_req_rdy_o}, 32'd0);
        tick();
        s_req_rdy_i = 1;
        #1;
        check("t4_m0_grant", {31'd0, m0_req_rdy_o}, 32'd1);
        check("t4_m0_addr", s_req_addr_o, 32'h4);
        tick();

        // 5. m0 stalls its response for three cycles.
        m0_req_vld_i = 0; s_req_rdy_i = 0;
        s_rsp_vld_i = 1; s_rsp_data_i = 32'hCAFE_0001; m0_rsp_rdy_i = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("t5_stall%0d_srdy", i), {31'd0, s_rsp_rdy_o}, 32'd0);
            check($sformatf("t5_stall%0d_vld", i), {31'd0, m0_rsp_vld_o}, 32'd1);
            check($sformatf("t5_stall%0d_data", i), m0_rsp_data_o, 32'hCAFE_0001);
            check($sformatf("t5_stall%0d_state", i), {30'd0, dut.state_q}, 32'd2);
            tick();
        end
        m0_rsp_rdy_i = 1;
        #1;
        check("t5_release_srdy", {31'd0, s_rsp_rdy_o}, 32'd1);
        tick();
        clear_inputs();
        check("t5_state", {30'd0, dut.state_q}, 32'd0);
        check("t5_prio", {31'd0, dut.prio_q}, 32'd1);

        // 6. Reset while m1 owns the slave in RSP.
        m1_req_vld_i = 1; m1_req_addr_i = 32'h30;
        tick();
        s_req_rdy_i = 1;
        tick();
        m1_req_vld_i = 0; s_req_rdy_i = 0; s_rsp_vld_i = 1; s_rsp_data_i = 32'h55;
        #1;
        check("t6_pre_state", {30'd0, dut.state_q}, 32'd2);
        check("t6_pre_owner", {31'd0, dut.owner_q}, 32'd1);
        rst_i = 1;
        tick();
        rst_i = 0;
        clear_inputs();
        check_all_zero("t6_rst");
        check("t6_state", {30'd0, dut.state_q}, 32'd0);
        check("t6_prio", {31'd0, dut.prio_q}, 32'd0);
        m0_req_vld_i = 1; m0_req_addr_i = 32'h4;
        m1_req_vld_i = 1; m1_req_addr_i = 32'h8;
        tick();
        s_req_rdy_i = 1;
        #1;
        check("t6_grant", {30'd0, m0_req_rdy_o, m1_req_rdy_o}, 32'd2);
        check("t6_addr", s_req_addr_o, 32'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
